// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: measures the interval between rising edges of an upstream spike flag,
// keeps a 4-deep running mean, and flags fast, slow and lost spike trains.
module spike_rate_monitor #(
  parameter int CNT_W   = 16,
  parameter int HI_THR  = 50,
  parameter int LO_THR  = 400,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid,
  output logic [CNT_W-1:0] avg_isi,
  output logic             avg_valid,
  output logic [CNT_W-1:0] beat_count,
  output logic             rate_hi,
  output logic             rate_lo,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOST  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HI_LIMIT  = CNT_W'(HI_THR);
  localparam logic [CNT_W-1:0] LO_LIMIT  = CNT_W'(LO_THR);
  localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam int               SUM_W     = CNT_W + 2;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             spike_prev_reg;
  logic [CNT_W-1:0] isi_reg;
  logic             isi_valid_reg;
  logic [CNT_W-1:0] avg_isi_reg;
  logic             avg_valid_reg;
  logic [CNT_W-1:0] beat_count_reg;
  logic             rate_hi_reg;
  logic             rate_lo_reg;
  logic             timeout_reg;
  logic [2:0]       fill_reg;
  logic [CNT_W-1:0] buf_reg  [0:3];

  logic             spike_event;
  logic             load_isi;
  logic             flush;
  logic [CNT_W-1:0] buf_next [0:3];
  logic [2:0]       fill_next;
  logic [SUM_W-1:0] sum_next;

  assign spike_event = spike && !spike_prev_reg;
  // A new interval is only produced from ARMED; recovery from LOST restarts the average.
  assign load_isi    = (state_reg == ARMED) && spike_event;
  assign flush       = (state_reg == LOST) && spike_event;

  always_comb begin
    buf_next[0] = buf_reg[0];
    if (flush) begin
      buf_next[0] = '0;
    end else if (load_isi) begin
      buf_next[0] = cnt_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_shift
      always_comb begin
        buf_next[gi] = buf_reg[gi];
        if (flush) begin
          buf_next[gi] = '0;
        end else if (load_isi) begin
          buf_next[gi] = buf_reg[gi-1];
        end
      end
    end
  endgenerate

  always_comb begin
    fill_next = fill_reg;
    if (flush) begin
      fill_next = 3'd0;
    end else if (load_isi && (fill_reg != 3'd4)) begin
      fill_next = fill_reg + 3'd1;
    end
  end

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < 4; i++) begin
      sum_next = sum_next + SUM_W'(buf_next[i]);
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (reset) begin
          buf_reg[gi] <= '0;
        end else begin
          buf_reg[gi] <= buf_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      spike_prev_reg <= 1'b0;
      isi_reg        <= '0;
      isi_valid_reg  <= 1'b0;
      avg_isi_reg    <= '0;
      avg_valid_reg  <= 1'b0;
      beat_count_reg <= '0;
      rate_hi_reg    <= 1'b0;
      rate_lo_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
      fill_reg       <= 3'd0;
    end else begin
      spike_prev_reg <= spike;
      isi_valid_reg  <= 1'b0;
      fill_reg       <= fill_next;

      if (spike_event && (beat_count_reg != CNT_MAX)) begin
        beat_count_reg <= beat_count_reg + CNT_ONE;
      end

      case (state_reg)
        IDLE: begin
          if (spike_event) begin
            state_reg <= ARMED;
            cnt_reg   <= CNT_ONE;
          end
        end

        ARMED: begin
          if (spike_event) begin
            cnt_reg       <= CNT_ONE;
            isi_reg       <= cnt_reg;
            isi_valid_reg <= 1'b1;
            rate_hi_reg   <= (cnt_reg < HI_LIMIT);
            rate_lo_reg   <= (cnt_reg > LO_LIMIT);
            avg_isi_reg   <= sum_next[SUM_W-1:2];
            avg_valid_reg <= (fill_next == 3'd4);
          end else if (cnt_reg >= TO_LIMIT) begin
            state_reg   <= LOST;
            timeout_reg <= 1'b1;
            rate_lo_reg <= 1'b1;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        LOST: begin
          if (spike_event) begin
            state_reg     <= ARMED;
            cnt_reg       <= CNT_ONE;
            timeout_reg   <= 1'b0;
            avg_isi_reg   <= '0;
            avg_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign isi        = isi_reg;
  assign isi_valid  = isi_valid_reg;
  assign avg_isi    = avg_isi_reg;
  assign avg_valid  = avg_valid_reg;
  assign beat_count = beat_count_reg;
  assign rate_hi    = rate_hi_reg;
  assign rate_lo    = rate_lo_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor: interval, averaging, threshold, timeout and reset cases.
module tb_spike_rate_monitor;

  logic        clk;
  logic        reset;
  logic        spike;
  logic [15:0] isi;
  logic        isi_valid;
  logic [15:0] avg_isi;
  logic        avg_valid;
  logic [15:0] beat_count;
  logic        rate_hi;
  logic        rate_lo;
  logic        timeout;

  int checks;
  int errors;

  spike_rate_monitor #(
    .CNT_W(16), .HI_THR(50), .LO_THR(400), .TIMEOUT(1000)
  ) dut (
    .clk(clk), .reset(reset), .spike(spike),
    .isi(isi), .isi_valid(isi_valid),
    .avg_isi(avg_isi), .avg_valid(avg_valid),
    .beat_count(beat_count),
    .rate_hi(rate_hi), .rate_lo(rate_lo), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Single-cycle spike; returns in the cycle after the event.
  task automatic first_spike();
    spike = 1'b1;
    step(1);
    spike = 1'b0;
  endtask

  // Next spike event `gap` cycles after the previous one.
  task automatic gap_spike(input int gap);
    spike = 1'b0;
    step(gap - 1);
    spike = 1'b1;
    step(1);
    spike = 1'b0;
  endtask

  task automatic do_reset();
    spike = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    spike  = 1'b0;
    #2;

    // Reset state
    do_reset();
    chk("rst_isi", 32'(isi), 0);
    chk("rst_isi_valid", 32'(isi_valid), 0);
    chk("rst_avg", 32'(avg_isi), 0);
    chk("rst_avg_valid", 32'(avg_valid), 0);
    chk("rst_beat", 32'(beat_count), 0);
    chk("rst_flags", {29'd0, rate_hi, rate_lo, timeout}, 0);

    // Three spikes 100 cycles apart
    first_spike();
    chk("idle_no_isi", 32'(isi_valid), 0);
    chk("idle_beat", 32'(beat_count), 1);
    gap_spike(100);
    chk("p100_valid", 32'(isi_valid), 1);
    chk("p100_isi", 32'(isi), 100);
    gap_spike(100);
    chk("p100b_isi", 32'(isi), 100);
    chk("p100b_beat", 32'(beat_count), 3);
    chk("p100b_hilo", {30'd0, rate_hi, rate_lo}, 0);
    chk("p100b_avg_valid", 32'(avg_valid), 0);
    step(1);
    chk("isi_valid_pulse", 32'(isi_valid), 0);

    // Five spikes 30 apart
    do_reset();
    first_spike();
    gap_spike(30);
    chk("p30_isi", 32'(isi), 30);
    chk("p30_rate_hi", 32'(rate_hi), 1);
    gap_spike(30);
    gap_spike(30);
    chk("p30_3rd_avg_valid", 32'(avg_valid), 0);
    gap_spike(30);
    chk("p30_avg_valid", 32'(avg_valid), 1);
    chk("p30_avg", 32'(avg_isi), 30);

    // Timeout after silence; average flushed on recovery
    spike = 1'b0;
    step(999);
    chk("to_before", 32'(timeout), 0);
    step(1);
    chk("to_set", 32'(timeout), 1);
    chk("to_rate_lo", 32'(rate_lo), 1);
    step(50);
    first_spike();
    chk("rec_timeout", 32'(timeout), 0);
    chk("rec_no_isi", 32'(isi_valid), 0);
    chk("rec_avg_valid", 32'(avg_valid), 0);
    chk("rec_beat", 32'(beat_count), 6);
    // Spike exactly at cnt=TIMEOUT is a normal interval
    gap_spike(1000);
    chk("edge_to_isi", 32'(isi), 1000);
    chk("edge_to_valid", 32'(isi_valid), 1);
    chk("edge_to_timeout", 32'(timeout), 0);
    chk("edge_to_rate_lo", 32'(rate_lo), 1);

    // Averaging of 100,101,102,104 then a slow 500
    do_reset();
    first_spike();
    gap_spike(100);
    gap_spike(101);
    gap_spike(102);
    chk("avg_3rd_valid", 32'(avg_valid), 0);
    gap_spike(104);
    chk("avg_4th_valid", 32'(avg_valid), 1);
    chk("avg_407", 32'(avg_isi), 101);
    chk("avg_isi104", 32'(isi), 104);
    gap_spike(500);
    chk("slow_rate_lo", 32'(rate_lo), 1);
    chk("slow_avg_807", 32'(avg_isi), 201);
    // HI_THR boundary: 50 is not fast, 49 is
    gap_spike(50);
    chk("thr50_rate_hi", 32'(rate_hi), 0);
    chk("thr50_rate_lo", 32'(rate_lo), 0);
    gap_spike(49);
    chk("thr49_rate_hi", 32'(rate_hi), 1);

    // Spike held high counts once
    do_reset();
    first_spike();
    spike = 1'b0;
    step(19);
    spike = 1'b1;
    step(5);
    spike = 1'b0;
    chk("held_beat", 32'(beat_count), 2);
    chk("held_isi", 32'(isi), 20);
    gap_spike(36);
    chk("held_next_isi", 32'(isi), 40);
    chk("held_next_beat", 32'(beat_count), 3);

    // Reset coincident with a spike event in ARMED
    gap_spike(10);
    spike = 1'b0;
    step(9);
    spike = 1'b1;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    spike = 1'b0;
    chk("rstspk_beat", 32'(beat_count), 0);
    chk("rstspk_isi", 32'(isi), 0);
    chk("rstspk_valid", {30'd0, isi_valid, avg_valid}, 0);
    chk("rstspk_avg", 32'(avg_isi), 0);
    chk("rstspk_flags", {29'd0, rate_hi, rate_lo, timeout}, 0);
    step(3);
    first_spike();
    chk("rstspk_no_isi", 32'(isi_valid), 0);
    chk("rstspk_beat1", 32'(beat_count), 1);
    gap_spike(40);
    chk("rstspk_isi40", 32'(isi), 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
